pc_sequencer: RTL and testbench

Owns the program counter and decides the next fetch address each cycle. It chooses between sequential PC+4 and the branch/jump targets computed by the branch unit. After every taken redirect it runs a flush window that squashes wrong-path instructions already in IF/ID. It also keeps a saturating redirect counter for performance debug.

---
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer: selects sequential or redirect fetch address,
// runs a post-redirect flush window and counts taken redirects.
module pc_sequencer #(
  parameter int unsigned       DATA_W       = 16,
  parameter logic [DATA_W-1:0] RESET_PC     = '0,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter int unsigned       CNT_W        = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic [DATA_W-1:0] jump_pc,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] updated_pc,
  output logic              flush,
  output logic              redirect,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam int unsigned FC_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [FC_W-1:0]   fcnt, fcnt_nxt;
  logic [DATA_W-1:0] pc_nxt;
  logic [DATA_W-1:0] target_raw;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              flush_nxt, redirect_nxt, misalign_nxt;
  logic              take, advance;

  assign updated_pc = pc + DATA_W'(4);
  assign take       = jump | (branch & branch_taken);
  assign target_raw = jump ? jump_pc : branch_pc;
  assign advance    = enable & ~stall;

  // State and datapath registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      fcnt         <= '0;
      pc           <= RESET_PC;
      flush        <= 1'b0;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_nxt;
      fcnt         <= fcnt_nxt;
      pc           <= pc_nxt;
      flush        <= flush_nxt;
      redirect     <= redirect_nxt;
      misalign_err <= misalign_nxt;
      redirect_cnt <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (advance && take) state_nxt = FLUSH;
      FLUSH:   if (advance && (fcnt <= FC_W'(1))) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of registered outputs; pulses default low every cycle
  always_comb begin
    pc_nxt       = pc;
    fcnt_nxt     = fcnt;
    flush_nxt    = flush;
    redirect_nxt = 1'b0;
    misalign_nxt = 1'b0;
    cnt_nxt      = redirect_cnt;
    case (state)
      RUN: begin
        if (advance) begin
          if (take) begin
            pc_nxt       = {target_raw[DATA_W-1:2], 2'b00};
            fcnt_nxt     = FC_W'(FLUSH_CYCLES);
            flush_nxt    = 1'b1;
            redirect_nxt = 1'b1;
            misalign_nxt = |target_raw[1:0];
            if (!(&redirect_cnt)) cnt_nxt = redirect_cnt + CNT_W'(1);
          end else begin
            pc_nxt = updated_pc;
          end
        end
      end
      FLUSH: begin
        if (advance) begin
          pc_nxt    = updated_pc;
          fcnt_nxt  = fcnt - FC_W'(1);
          flush_nxt = (fcnt != FC_W'(1));
        end
      end
      default: ;
    endcase
    if (cnt_clr) cnt_nxt = '0;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (DATA_W=16, FLUSH_CYCLES=2, CNT_W=2).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable, stall, branch, branch_taken, jump, cnt_clr;
  logic [15:0] branch_pc, jump_pc;
  logic [15:0] pc, updated_pc;
  logic        flush, redirect, misalign_err;
  logic [1:0]  redirect_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .DATA_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(2), .CNT_W(2)
  ) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .stall(stall),
    .branch(branch), .branch_taken(branch_taken), .jump(jump),
    .branch_pc(branch_pc), .jump_pc(jump_pc), .cnt_clr(cnt_clr),
    .pc(pc), .updated_pc(updated_pc), .flush(flush), .redirect(redirect),
    .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] epc, input logic efl,
                         input logic erd, input logic emis, input logic [1:0] ecnt);
    chk({tag, ".pc"},       32'(pc), 32'(epc));
    chk({tag, ".flush"},    32'(flush), 32'(efl));
    chk({tag, ".redirect"}, 32'(redirect), 32'(erd));
    chk({tag, ".misalign"}, 32'(misalign_err), 32'(emis));
    chk({tag, ".cnt"},      32'(redirect_cnt), 32'(ecnt));
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b0; stall = 1'b0; branch = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; cnt_clr = 1'b0; branch_pc = '0; jump_pc = '0;
    #3;
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset.updated_pc", 32'(updated_pc), 32'h0004);
    step(); step();
    arst_n = 1'b1;

    // IDLE holds with enable low, then the IDLE->RUN cycle holds pc
    step();
    chk("idle.pc", 32'(pc), 32'h0000);
    enable = 1'b1;
    step();
    chk("idle2run.pc", 32'(pc), 32'h0000);
    step(); chk_all("seq1", 16'h0004, 1'b0, 1'b0, 1'b0, 2'd0);
    step(); chk_all("seq2", 16'h0008, 1'b0, 1'b0, 1'b0, 2'd0);
    step(); chk("seq3.pc", 32'(pc), 32'h000C);
    step(); chk("seq4.pc", 32'(pc), 32'h0010);

    // taken branch at 0x0010
    branch = 1'b1; branch_taken = 1'b1; branch_pc = 16'h0040;
    step(); chk_all("br.n1", 16'h0040, 1'b1, 1'b1, 1'b0, 2'd1);
    branch = 1'b0; branch_taken = 1'b0;
    step(); chk_all("br.n2", 16'h0044, 1'b1, 1'b0, 1'b0, 2'd1);
    step(); chk_all("br.n3", 16'h0048, 1'b0, 1'b0, 1'b0, 2'd1);
    step(); chk_all("br.n4", 16'h004C, 1'b0, 1'b0, 1'b0, 2'd1);

    // jump beats taken branch; jump held into FLUSH is ignored
    jump = 1'b1; jump_pc = 16'h0100; branch = 1'b1; branch_taken = 1'b1; branch_pc = 16'h0200;
    step(); chk_all("jb.n1", 16'h0100, 1'b1, 1'b1, 1'b0, 2'd2);
    jump_pc = 16'h0300; branch = 1'b0; branch_taken = 1'b0;
    step(); chk_all("jb.ignored", 16'h0104, 1'b1, 1'b0, 1'b0, 2'd2);
    jump = 1'b0;
    step(); chk_all("jb.n3", 16'h0108, 1'b0, 1'b0, 1'b0, 2'd2);

    // stall three cycles inside the flush window
    jump = 1'b1; jump_pc = 16'h0200;
    step(); chk_all("st.redir", 16'h0200, 1'b1, 1'b1, 1'b0, 2'd3);
    jump = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("st.hold", 16'h0200, 1'b1, 1'b0, 1'b0, 2'd3);
    end
    stall = 1'b0;
    step(); chk_all("st.f2", 16'h0204, 1'b1, 1'b0, 1'b0, 2'd3);
    step(); chk_all("st.end", 16'h0208, 1'b0, 1'b0, 1'b0, 2'd3);

    // misaligned jump; counter already saturated
    jump = 1'b1; jump_pc = 16'h0123;
    step(); chk_all("mis.n1", 16'h0120, 1'b1, 1'b1, 1'b1, 2'd3);
    jump = 1'b0;
    step(); chk_all("mis.n2", 16'h0124, 1'b1, 1'b0, 1'b0, 2'd3);
    step(); chk_all("mis.n3", 16'h0128, 1'b0, 1'b0, 1'b0, 2'd3);

    // fifth redirect via misaligned branch target, stays saturated
    branch = 1'b1; branch_taken = 1'b1; branch_pc = 16'h0302;
    step(); chk_all("sat.n1", 16'h0300, 1'b1, 1'b1, 1'b1, 2'd3);
    branch = 1'b0; branch_taken = 1'b0;
    step(); step(); chk_all("sat.n3", 16'h0308, 1'b0, 1'b0, 1'b0, 2'd3);

    // branch not taken advances sequentially
    branch = 1'b1; branch_taken = 1'b0; branch_pc = 16'h0500;
    step(); chk_all("nt", 16'h030C, 1'b0, 1'b0, 1'b0, 2'd3);
    branch = 1'b0;

    // clear wins over increment; then wrap at 0xFFFC
    cnt_clr = 1'b1; jump = 1'b1; jump_pc = 16'hFFF0;
    step(); chk_all("clr.n1", 16'hFFF0, 1'b1, 1'b1, 1'b0, 2'd0);
    cnt_clr = 1'b0; jump = 1'b0;
    step(); chk("wrap.fff4", 32'(pc), 32'hFFF4);
    step(); chk("wrap.fff8", 32'(pc), 32'hFFF8);
    step(); chk("wrap.fffc", 32'(pc), 32'hFFFC);
    chk("wrap.updated_pc", 32'(updated_pc), 32'h0000);
    step(); chk_all("wrap.zero", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);

    // enable low in RUN freezes pc
    enable = 1'b0;
    step(); chk("en0.a", 32'(pc), 32'h0000);
    step(); chk("en0.b", 32'(pc), 32'h0000);
    enable = 1'b1;
    step(); chk("en1", 32'(pc), 32'h0004);

    // enable low in FLUSH with cnt_clr; then reset mid-flush
    jump = 1'b1; jump_pc = 16'h0040;
    step(); chk_all("fl.redir", 16'h0040, 1'b1, 1'b1, 1'b0, 2'd1);
    jump = 1'b0; enable = 1'b0; cnt_clr = 1'b1;
    step(); chk_all("fl.en0clr", 16'h0040, 1'b1, 1'b0, 1'b0, 2'd0);
    enable = 1'b1; cnt_clr = 1'b0;
    step(); chk_all("fl.resume", 16'h0044, 1'b1, 1'b0, 1'b0, 2'd0);
    #2 arst_n = 1'b0;
    #1;
    chk_all("arst", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("arst.updated_pc", 32'(updated_pc), 32'h0004);
    step(); step();
    arst_n = 1'b1;
    step(); chk_all("post_arst.idle", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
    step(); chk("post_arst.run", 32'(pc), 32'h0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
